// File: rtl/fpu_mul_result_q.sv
// fpu_mul_result_q
// First clocked stage after the FP32 multiplier: a DEPTH-entry result FIFO
// holding {oom, vec, flag, c}, plus sticky exception bits and saturating
// oom/vec event counters for software readout.
module fpu_mul_result_q #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_c,
    input  logic                     in_flag,
    input  logic                     in_oom,
    input  logic                     in_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_c,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     clr_stats,
    output logic                     sticky_oom,
    output logic                     sticky_vec,
    output logic [CNT_W-1:0]         oom_cnt,
    output logic [CNT_W-1:0]         vec_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);

    // Entry layout: [34]=oom, [33]=vec, [32]=flag, [31:0]=product word
    logic [34:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic           r_sticky_oom;
    logic           r_sticky_vec;
    logic [CNT_W-1:0] r_oom_cnt;
    logic [CNT_W-1:0] r_vec_cnt;

    logic           w_push;
    logic           w_pop;
    logic           w_oom_ev;
    logic           w_vec_ev;
    logic [34:0]    w_head;

    // Handshakes come from registered level only, so no input-to-output
    // combinational path exists; a full queue refuses a push even if popped.
    assign in_ready  = (r_level != LVL_FULL);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_oom_ev  = w_push & in_oom;
    assign w_vec_ev  = w_push & in_vec;

    // Head is read straight out of storage; stale when empty by design.
    assign w_head    = r_mem[r_rd_ptr];
    assign out_c     = w_head[31:0];
    assign out_flags = w_head[34:32];

    assign level      = r_level;
    assign sticky_oom = r_sticky_oom;
    assign sticky_vec = r_sticky_vec;
    assign oom_cnt    = r_oom_cnt;
    assign vec_cnt    = r_vec_cnt;

    // Storage write on accepted push; whole array cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {in_oom, in_vec, in_flag, in_c};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks net change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky bits: clear first, then an accepted event in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_oom <= 1'b0;
            r_sticky_vec <= 1'b0;
        end else begin
            r_sticky_oom <= (r_sticky_oom & ~clr_stats) | w_oom_ev;
            r_sticky_vec <= (r_sticky_vec & ~clr_stats) | w_vec_ev;
        end
    end

    // Saturating oom counter; clear with a concurrent event lands on 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oom_cnt <= '0;
        end else if (clr_stats) begin
            r_oom_cnt <= CNT_W'(w_oom_ev);
        end else if (w_oom_ev && r_oom_cnt != CNT_MAX) begin
            r_oom_cnt <= r_oom_cnt + CNT_W'(1);
        end
    end

    // Saturating vec counter; same clear/set priority as the oom counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_cnt <= '0;
        end else if (clr_stats) begin
            r_vec_cnt <= CNT_W'(w_vec_ev);
        end else if (w_vec_ev && r_vec_cnt != CNT_MAX) begin
            r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fpu_mul_result_q.sv
// Bench for fpu_mul_result_q: directed test-plan steps plus a random phase,
// checked against a queue-based reference model.
module tb_fpu_mul_result_q;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_c = '0;
    logic        in_flag = 1'b0;
    logic        in_oom = 1'b0;
    logic        in_vec = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [2:0]  out_flags;
    logic [$clog2(DEPTH):0] level;
    logic        clr_stats = 1'b0;
    logic        sticky_oom;
    logic        sticky_vec;
    logic [CNT_W-1:0] oom_cnt;
    logic [CNT_W-1:0] vec_cnt;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [34:0] q[$];
    int  m_oc = 0, m_vc = 0;
    bit  m_so = 0, m_sv = 0;

    fpu_mul_result_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_flag(in_flag), .in_oom(in_oom), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_flags(out_flags), .level(level),
        .clr_stats(clr_stats),
        .sticky_oom(sticky_oom), .sticky_vec(sticky_vec),
        .oom_cnt(oom_cnt), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},     64'(level),     64'(q.size()));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < DEPTH));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk({tag, ".out_c"},     64'(out_c),     64'(q[0][31:0]));
            chk({tag, ".out_flags"}, 64'(out_flags), 64'(q[0][34:32]));
        end
        chk({tag, ".sticky_oom"}, 64'(sticky_oom), 64'(m_so));
        chk({tag, ".sticky_vec"}, 64'(sticky_vec), 64'(m_sv));
        chk({tag, ".oom_cnt"},    64'(oom_cnt),    64'(m_oc));
        chk({tag, ".vec_cnt"},    64'(vec_cnt),    64'(m_vc));
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic step(input string tag, input bit v, input logic [31:0] c,
                        input bit f, input bit o, input bit vv,
                        input bit rdy, input bit clr);
        bit do_push, do_pop;
        in_valid = v; in_c = c; in_flag = f; in_oom = o; in_vec = vv;
        out_ready = rdy; clr_stats = clr;
        do_push = v && (q.size() < DEPTH);
        do_pop  = rdy && (q.size() > 0);
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({o, vv, f, c});
        if (clr) begin m_oc = 0; m_vc = 0; m_so = 0; m_sv = 0; end
        if (do_push && o)  begin m_so = 1; if (m_oc < MAXC) m_oc++; end
        if (do_push && vv) begin m_sv = 1; if (m_vc < MAXC) m_vc++; end
        @(negedge clk);
        in_valid = 0; out_ready = 0; clr_stats = 0;
        check_all(tag);
    endtask

    initial begin
        // reset then idle
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst.out_c", 64'(out_c), 64'h0);
        chk("rst.out_flags", 64'(out_flags), 64'h0);
        check_all("rst");
        for (int i = 0; i < 10; i++) step("idle", 0, 32'h0, 0, 0, 0, 0, 0);
        chk("idle.out_c", 64'(out_c), 64'h0);

        // two pushes, no pop
        step("p1", 1, 32'h40C00000, 0, 0, 0, 0, 0);
        step("p2", 1, 32'h7F800000, 0, 1, 0, 0, 0);
        chk("p2.level", 64'(level), 64'd2);
        chk("p2.head", 64'(out_c), 64'h40C00000);
        chk("p2.oom_cnt", 64'(oom_cnt), 64'd1);
        step("pop1", 0, 32'h0, 0, 0, 0, 1, 0);
        chk("pop1.out_c", 64'(out_c), 64'h7F800000);
        chk("pop1.flags", 64'(out_flags), 64'b100);
        step("pop2", 0, 32'h0, 0, 0, 0, 1, 0);

        // fill to full, refused pushes, drain
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1, 32'hA000_0000 + i, i[0], 0, i[1], 0, 0);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        step("full.push5", 1, 32'hDEAD0005, 0, 0, 0, 0, 0);
        chk("full.level4", 64'(level), 64'd4);
        step("full.pushpop", 1, 32'hDEAD0006, 0, 0, 0, 1, 0);
        chk("full.level3", 64'(level), 64'd3);
        step("full.push7", 1, 32'hBEEF0007, 0, 0, 0, 0, 0);
        chk("full.level4b", 64'(level), 64'd4);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 32'h0, 0, 0, 0, 1, 0);
        chk("drain.empty", 64'(out_valid), 64'd0);

        // streaming, one push and pop per cycle
        for (int i = 0; i < 20; i++) begin
            step("stream", 1, 32'h1000 + i, 0, 0, 0, 1, 0);
            chk("stream.level", 64'(level), 64'd1);
            chk("stream.out_c", 64'(out_c), 64'(32'h1000 + i));
        end
        step("stream.end", 0, 32'h0, 0, 0, 0, 1, 0);

        // vec counter saturation, then clear racing a vec push
        for (int i = 0; i < 300; i++) step("sat", 1, 32'h0000_0100 + i, 0, 0, 1, 1, 0);
        chk("sat.vec_cnt", 64'(vec_cnt), 64'd255);
        chk("sat.sticky", 64'(sticky_vec), 64'd1);
        step("clrset", 1, 32'h5555, 0, 0, 1, 1, 1);
        chk("clrset.vec_cnt", 64'(vec_cnt), 64'd1);
        chk("clrset.sticky", 64'(sticky_vec), 64'd1);
        step("clr", 0, 32'h0, 0, 0, 0, 1, 1);
        chk("clr.vec_cnt", 64'(vec_cnt), 64'd0);

        // random traffic
        for (int i = 0; i < 200; i++)
            step("rand", bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);

        // async reset mid-cycle at level 3
        while (q.size() > 0) step("pre.drain", 0, 32'h0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("pre.fill", 1, 32'hC000_0000 + i, 0, 1, 1, 0, 0);
        chk("pre.level3", 64'(level), 64'd3);
        #2 rst = 1;
        #1;
        chk("arst.level", 64'(level), 64'd0);
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.out_c", 64'(out_c), 64'd0);
        chk("arst.out_flags", 64'(out_flags), 64'd0);
        chk("arst.sticky_oom", 64'(sticky_oom), 64'd0);
        chk("arst.oom_cnt", 64'(oom_cnt), 64'd0);
        chk("arst.vec_cnt", 64'(vec_cnt), 64'd0);
        q.delete(); m_oc = 0; m_vc = 0; m_so = 0; m_sv = 0;
        @(negedge clk);
        rst = 0;
        step("post", 1, 32'h3F800000, 1, 0, 0, 0, 0);
        chk("post.head", 64'(out_c), 64'h3F800000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
